led_sequencer: RTL
==================

// Module: led_sequencer
// PURPOSE
//  Parametrised colour sequencer that replaces the fixed RED..MAGENTA loop in top. It steps through a
//  run-time-programmable table of 32-bit colour words and writes each word to the memory-mapped LED
//  register through the memory block's dmem write port. It has loop, one-shot and ping-pong modes,
//  a per-step dwell counter, start/stop control and a write stall on dmem_busy.
// PARAMETERS
//  NUM_STEPS     6             number of table entries (>=1)
//  DWELL_W       22            width of dwell counter and dwell_cycles
//  LED_ADDR      32'hFFFFFFFC  dmem address of the LED register
//  DEFAULT_TABLE {6 x 32b}     reset table contents, entry 0 in LSBs:
//                              FFFF0000,FFFFFF00,FF00FF00,0000FFFF,000000FF,00FF00FF
//  IDX_W         $clog2(NUM_STEPS) or 1 if NUM_STEPS==1 (derived)
// PORTS
//  clk           in   1      clock; all logic on negedge clk, matching the memory block
//  reset         in   1      synchronous, active-high reset
//  start         in   1      pulse; starts a sequence from step 0 (honoured in IDLE/DONE only)
//  stop          in   1      pulse; aborts the sequence to IDLE
//  mode          in   2      0 loop, 1 one-shot, 2 ping-pong, 3 reserved (=loop); sampled at start
//  dwell_cycles  in   DWELL_W  cycles spent in DWELL per step; sampled at start; 0 is treated as 1
//  tbl_wren      in   1      table write enable
//  tbl_idx       in   IDX_W  table write index
//  tbl_data      in   32     table write data
//  dmem_busy     in   1      memory cannot accept a write this cycle
//  dmem_wren     out  1      dmem write enable
//  dmem_address  out  32     always LED_ADDR
//  dmem_data_in  out  32     colour word being written
//  funct3        out  3      constant 3'b010 (SW)
//  busy          out  1      high in WRITE or DWELL
//  done          out  1      high in DONE
//  step_idx      out  IDX_W  current table index
// BEHAVIOUR
//  Reset values: state IDLE, step_idx 0, direction up, count 0, dmem_wren 0, dmem_data_in 0,
//   busy 0, done 0, table = DEFAULT_TABLE.
//  States: IDLE, WRITE, DWELL, DONE.
//  - IDLE/DONE: start -> WRITE. On that edge, latch mode and dwell, set step_idx=0 and direction up,
//    and capture dmem_data_in=table[0]. dmem_wren is high on the first edge after start (latency 1).
//  - WRITE: dmem_wren=1, with dmem_data_in held stable. If dmem_busy, stay in WRITE.
//    If !dmem_busy, the write commits that cycle -> DWELL with count=dwell-1 and dmem_wren=0.
//  - DWELL: lasts exactly max(dwell,1) cycles, then selects the next step and enters WRITE.
//    On entry to WRITE, dmem_data_in is captured as table[next].
//     loop:      last -> 0.
//     one-shot:  after the last step's dwell -> DONE. dmem_data_in keeps the last colour.
//     ping-pong: 0..N-1..0 with no endpoint repeat (N=6 gives 0,1,2,3,4,5,4,3,...,1,0,1).
//    With NUM_STEPS==1: loop and ping-pong rewrite step 0 each period; one-shot writes once.
//  - stop in any state -> IDLE next edge with dmem_wren=0. stop wins over a simultaneous start.
//    start while in WRITE/DWELL is ignored.
//  - Table: tbl_wren writes table[tbl_idx] on the edge. tbl_idx>=NUM_STEPS is ignored.
//    The word for a step is captured on entry to WRITE, so a write to the active entry applies
//    only from its next visit.
//  - reset mid-sequence: all state and the table return to reset values; no dmem write that cycle.
// CONFIGURATION
//  LED_SEQ_PINGPONG_EN defined: mode 2 behaves as ping-pong above.
//  LED_SEQ_PINGPONG_EN undefined: no direction register is built, and mode 2 behaves as loop.
// STRUCTURE
//  led_seq_pkg holds:
//   - typedef enum state_t {IDLE,WRITE,DWELL,DONE}
//   - typedef enum mode_t {MODE_LOOP,MODE_ONESHOT,MODE_PINGPONG}
//   - localparam FUNCT3_SW = 3'b010
//  One sub-module, led_seq_table: NUM_STEPS x 32 register file with reset-to-DEFAULT_TABLE,
//  one write port and one async read port.
// TESTING
//  1. reset, mode=0, dwell=3, start -> writes FFFF0000,FFFFFF00,...,00FF00FF, then FFFF0000 again;
//     writes are 4 cycles apart; dmem_address FFFFFFFC and funct3 010 on every write.
//  2. mode=1, dwell=2 -> exactly 6 writes, then done=1 and busy=0; a second start repeats
//     the sequence.
//  3. mode=2, NUM_STEPS=6 -> step_idx sequence 0,1,2,3,4,5,4,3,2,1,0,1. With the macro undefined,
//     the sequence is 0..5,0.
//  4. dmem_busy held high for 5 cycles at the step-2 write -> wren stays 1 and data stays FF00FF00
//     for 6 cycles; a single commit; dwell timing restarts after the commit.
//  5. stop during DWELL, and stop coincident with start in IDLE -> IDLE, wren 0, no further writes.
//  6. tbl_wren idx=1 data=12345678 during step 1's WRITE -> the current write is still FFFFFF00 and
//     the next loop writes 12345678; idx=6 is ignored; reset mid-DWELL restores table and IDLE.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED colour sequencer.
//   state_t : sequencer FSM states
//   mode_t  : latched sequencing mode (reserved mode 3 decodes to MODE_LOOP)
//   FUNCT3_SW : store-word funct3 presented on every dmem write
package led_seq_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, DWELL, DONE} state_t;

   typedef enum logic [1:0] {MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG} mode_t;

   localparam logic [2:0] FUNCT3_SW = 3'b010;

endpackage

// File: rtl/led_seq_table.sv
// Colour table for the LED sequencer: NUM_STEPS x 32-bit register file that
// resets to DEFAULT_TABLE (entry 0 in the LSBs), one write port, one async read.
// Ports:
//   clk      in   clock (negedge-active, like the memory block)
//   reset    in   synchronous active-high reset
//   wren     in   write enable
//   wr_idx   in   write index; indices >= NUM_STEPS are ignored
//   wr_data  in   write data
//   rd_idx   in   read index
//   rd_data  out  table[rd_idx]
module led_seq_table
   import led_seq_pkg::*;
#(
   parameter int                      NUM_STEPS     = 6,
   parameter int                      IDX_W         = 3,
   parameter logic [NUM_STEPS*32-1:0] DEFAULT_TABLE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wren,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   logic [31:0] mem [NUM_STEPS];

   always_ff @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            mem[i] <= DEFAULT_TABLE[i*32 +: 32];
         end
      end else if (wren && (int'(wr_idx) < NUM_STEPS)) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/led_sequencer.sv
// LED colour sequencer: steps through a programmable colour table and writes
// each word to the memory-mapped LED register via the dmem write port, with
// loop / one-shot / ping-pong modes, per-step dwell, start/stop and a write
// stall on dmem_busy. All logic runs on the falling clock edge.
// Build option: define LED_SEQ_PINGPONG_EN to build the ping-pong direction
// register; without it mode 2 runs as loop.
//
//   state | meaning
//   IDLE  | stopped, waiting for start
//   WRITE | dmem_wren high, holding colour until the memory accepts it
//   DWELL | counting down the per-step dwell before the next step
//   DONE  | one-shot finished, last colour still presented
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, stop           control pulses (stop wins)
//   mode, dwell_cycles    sequencing mode and per-step dwell, sampled at start
//   tbl_wren/idx/data     colour table write port
//   dmem_busy             memory cannot accept a write this cycle
//   dmem_wren/address/data_in, funct3   dmem write port
//   busy, done, step_idx  status
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int                      NUM_STEPS     = 6,
   parameter int                      DWELL_W       = 22,
   parameter logic [31:0]             LED_ADDR      = 32'hFFFF_FFFC,
   parameter logic [NUM_STEPS*32-1:0] DEFAULT_TABLE = {32'h00FF_00FF, 32'h0000_00FF,
                                                       32'h0000_FFFF, 32'hFF00_FF00,
                                                       32'hFFFF_FF00, 32'hFFFF_0000},
   parameter int                      IDX_W         = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [1:0]         mode,
   input  logic [DWELL_W-1:0] dwell_cycles,
   input  logic               tbl_wren,
   input  logic [IDX_W-1:0]   tbl_idx,
   input  logic [31:0]        tbl_data,
   input  logic               dmem_busy,
   output logic               dmem_wren,
   output logic [31:0]        dmem_address,
   output logic [31:0]        dmem_data_in,
   output logic [2:0]         funct3,
   output logic               busy,
   output logic               done,
   output logic [IDX_W-1:0]   step_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

   state_t             state, state_nxt;
   mode_t              mode_q, mode_nxt;
   logic [DWELL_W-1:0] dwell_q, dwell_nxt;
   logic [DWELL_W-1:0] count, count_nxt;
   logic [IDX_W-1:0]   step_nxt, adv_idx, rd_idx;
   logic [31:0]        data_nxt, rd_data;
   logic               adv_done;
`ifdef LED_SEQ_PINGPONG_EN
   logic               dir_up, dir_nxt, adv_up;
`endif

   led_seq_table #(
      .NUM_STEPS     (NUM_STEPS),
      .IDX_W         (IDX_W),
      .DEFAULT_TABLE (DEFAULT_TABLE)
   ) u_table (
      .clk     (clk),
      .reset   (reset),
      .wren    (tbl_wren),
      .wr_idx  (tbl_idx),
      .wr_data (tbl_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   assign dmem_address = LED_ADDR;
   assign funct3       = FUNCT3_SW;

   always_ff @(negedge clk) begin
      if (reset) begin
         state        <= IDLE;
         mode_q       <= MODE_LOOP;
         dwell_q      <= '0;
         count        <= '0;
         step_idx     <= '0;
         dmem_data_in <= '0;
`ifdef LED_SEQ_PINGPONG_EN
         dir_up       <= 1'b1;
`endif
      end else begin
         state        <= state_nxt;
         mode_q       <= mode_nxt;
         dwell_q      <= dwell_nxt;
         count        <= count_nxt;
         step_idx     <= step_nxt;
         dmem_data_in <= data_nxt;
`ifdef LED_SEQ_PINGPONG_EN
         dir_up       <= dir_nxt;
`endif
      end
   end

   // Step that follows step_idx in the latched mode; adv_done flags the end of a one-shot run.
   always_comb begin
      adv_idx  = step_idx;
      adv_done = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
      adv_up   = dir_up;
      if (mode_q == MODE_PINGPONG) begin
         if (NUM_STEPS == 1) begin
            adv_idx = '0;
         end else if (dir_up) begin
            if (step_idx == LAST_IDX) begin
               adv_idx = step_idx - 1'b1;
               adv_up  = 1'b0;
            end else begin
               adv_idx = step_idx + 1'b1;
            end
         end else begin
            if (step_idx == '0) begin
               adv_idx = step_idx + 1'b1;
               adv_up  = 1'b1;
            end else begin
               adv_idx = step_idx - 1'b1;
            end
         end
      end else begin
`else
      begin
`endif
         if (step_idx == LAST_IDX) begin
            adv_idx  = '0;
            adv_done = (mode_q == MODE_ONESHOT);
         end else begin
            adv_idx = step_idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      dwell_nxt = dwell_q;
      count_nxt = count;
      step_nxt  = step_idx;
      data_nxt  = dmem_data_in;
      rd_idx    = adv_idx;
`ifdef LED_SEQ_PINGPONG_EN
      dir_nxt   = dir_up;
`endif
      dmem_wren = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      unique case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start && !stop) begin
               state_nxt = WRITE;
               step_nxt  = '0;
               rd_idx    = '0;
               data_nxt  = rd_data;
               dwell_nxt = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
`ifdef LED_SEQ_PINGPONG_EN
               dir_nxt   = 1'b1;
`endif
               case (mode)
                  2'd1:    mode_nxt = MODE_ONESHOT;
`ifdef LED_SEQ_PINGPONG_EN
                  2'd2:    mode_nxt = MODE_PINGPONG;
`endif
                  default: mode_nxt = MODE_LOOP;
               endcase
            end
         end
         WRITE: begin
            dmem_wren = !reset;
            busy      = 1'b1;
            if (!dmem_busy) begin
               state_nxt = DWELL;
               count_nxt = dwell_q - 1'b1;
            end
         end
         DWELL: begin
            busy = 1'b1;
            if (count != '0) begin
               count_nxt = count - 1'b1;
            end else if (adv_done) begin
               state_nxt = DONE;
            end else begin
               state_nxt = WRITE;
               step_nxt  = adv_idx;
               data_nxt  = rd_data;
`ifdef LED_SEQ_PINGPONG_EN
               dir_nxt   = adv_up;
`endif
            end
         end
      endcase

      if (stop) begin
         state_nxt = IDLE;
         mode_nxt  = mode_q;
         dwell_nxt = dwell_q;
         count_nxt = count;
         step_nxt  = step_idx;
         data_nxt  = dmem_data_in;
`ifdef LED_SEQ_PINGPONG_EN
         dir_nxt   = dir_up;
`endif
      end
   end

endmodule
